// File: rtl/pipelined_component_counter_multi_if.sv
// Graph-feed and result bus of the component counter: valid/ready graph input,
// single-cycle result strobe with count, overflow flag and sideband.
interface pipelined_component_counter_multi_if #(
    parameter int VAR_COUNT        = 7,
    parameter int COUNT_WIDTH      = 6,
    parameter int EXTRA_DATA_WIDTH = 10
);
    logic                          in_valid;
    logic                          in_ready;
    logic [(1 << VAR_COUNT)-1:0]   graph_in;
    logic [EXTRA_DATA_WIDTH-1:0]   extra_in;
    logic                          out_valid;
    logic [COUNT_WIDTH-1:0]        count_out;
    logic                          overflow_out;
    logic [EXTRA_DATA_WIDTH-1:0]   extra_out;

    modport master (
        output in_valid, graph_in, extra_in,
        input  in_ready, out_valid, count_out, overflow_out, extra_out
    );

    modport slave (
        input  in_valid, graph_in, extra_in,
        output in_ready, out_valid, count_out, overflow_out, extra_out
    );
endinterface

// File: rtl/pipelined_component_counter_multi.sv
// Connected-component counter for 2^VAR_COUNT-bit graphs bounded by a top mask.
// LOOP_LATENCY graphs circulate in a slot ring; the head slot takes one step per visit.
module pipelined_component_counter_multi #(
    parameter int VAR_COUNT        = 7,
    parameter int LOOP_LATENCY     = 8,
    parameter int COUNT_WIDTH      = 6,
    parameter int EXTRA_DATA_WIDTH = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [(1 << VAR_COUNT)-1:0]          top,
    pipelined_component_counter_multi_if.slave   bus,
    output logic [$clog2(LOOP_LATENCY+1)-1:0]    busy_count
);
    localparam int W  = 1 << VAR_COUNT;
    localparam int LL = LOOP_LATENCY;
    localparam int BW = $clog2(LOOP_LATENCY + 1);
    localparam int CW = COUNT_WIDTH;
    localparam int XW = EXTRA_DATA_WIDTH;

    logic [LL-1:0]         slot_vld;
    logic [LL-1:0][W-1:0]  slot_l;
    logic [LL-1:0][W-1:0]  slot_e;
    logic [LL-1:0][CW-1:0] slot_cnt;
    logic [LL-1:0]         slot_ovf;
    logic [LL-1:0][XW-1:0] slot_extra;

    logic          head_done, head_free, finish, accept;
    logic          nxt_vld, nxt_ovf;
    logic [W-1:0]  nxt_l, nxt_e, seed_bit, grow;
    logic [CW-1:0] nxt_cnt;
    logic [XW-1:0] nxt_extra;

    // Bits whose index has variable v cleared.
    function automatic logic [W-1:0] var_mask(input int v);
        logic [W-1:0] m;
        m = '0;
        for (int i = W - 1; i >= 0; i--)
            m = {m[W-2:0], ((i >> v) & 1) == 0};
        return m;
    endfunction

    function automatic logic [W-1:0] up_close(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = x;
        for (int v = 0; v < VAR_COUNT; v++)
            r = r | ((r & var_mask(v)) << (1 << v));
        return r;
    endfunction

    function automatic logic [W-1:0] down_close(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = x;
        for (int v = 0; v < VAR_COUNT; v++)
            r = r | ((r >> (1 << v)) & var_mask(v));
        return r;
    endfunction

    function automatic logic [W-1:0] lowest_bit(input logic [W-1:0] x);
        return x & (~x + W'(1));
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + CW'(1);
    endfunction

    assign head_done    = (slot_e[0] == '0) && (slot_l[0] == '0);
    assign head_free    = !slot_vld[0] || head_done;
    assign finish       = slot_vld[0] && head_done;
    assign accept       = head_free && bus.in_valid && !rst;
    assign bus.in_ready = head_free && !rst;
    assign seed_bit     = lowest_bit(slot_l[0]);
    assign grow         = slot_l[0] & down_close(up_close(slot_e[0]) & top);

    always_comb begin
        nxt_vld   = slot_vld[0];
        nxt_l     = slot_l[0];
        nxt_e     = slot_e[0];
        nxt_cnt   = slot_cnt[0];
        nxt_ovf   = slot_ovf[0];
        nxt_extra = slot_extra[0];
        if (accept) begin
            nxt_vld   = 1'b1;
            nxt_l     = bus.graph_in;
            nxt_e     = '0;
            nxt_cnt   = '0;
            nxt_ovf   = 1'b0;
            nxt_extra = bus.extra_in;
        end else if (finish) begin
            nxt_vld = 1'b0;
        end else if (slot_vld[0]) begin
            if (slot_e[0] == '0) begin
                nxt_e   = seed_bit;
                nxt_l   = slot_l[0] & ~seed_bit;
                nxt_cnt = sat_inc(slot_cnt[0]);
                nxt_ovf = slot_ovf[0] | (&slot_cnt[0]);
            end else begin
                nxt_e = grow;
                nxt_l = slot_l[0] & ~grow;
            end
        end
    end

    // Ring advance: the head result re-enters at the tail, the rest move one step toward the head
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld   <= '0;
            busy_count <= '0;
        end else begin
            slot_vld   <= {nxt_vld, slot_vld[LL-1:1]};
            busy_count <= busy_count + BW'(accept && !slot_vld[0]) - BW'(finish && !accept);
        end
    end

    always_ff @(posedge clk) begin
        slot_l     <= {nxt_l, slot_l[LL-1:1]};
        slot_e     <= {nxt_e, slot_e[LL-1:1]};
        slot_cnt   <= {nxt_cnt, slot_cnt[LL-1:1]};
        slot_ovf   <= {nxt_ovf, slot_ovf[LL-1:1]};
        slot_extra <= {nxt_extra, slot_extra[LL-1:1]};
    end

    // Result register: loaded only on FINISH so the last result holds between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid    <= 1'b0;
            bus.count_out    <= '0;
            bus.overflow_out <= 1'b0;
            bus.extra_out    <= '0;
        end else begin
            bus.out_valid <= finish;
            if (finish) begin
                bus.count_out    <= slot_cnt[0];
                bus.overflow_out <= slot_ovf[0];
                bus.extra_out    <= slot_extra[0];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_component_counter_multi.sv
// Scoreboard bench: two counters (wide and 1-bit count) share one stimulus stream;
// expected results come from a graph-reachability model of component counting.
module tb_pipelined_component_counter_multi;
    localparam int VC  = 2;
    localparam int W   = 4;
    localparam int LL  = 4;
    localparam int CWA = 6;
    localparam int CWB = 1;
    localparam int EW  = 10;
    localparam int BW  = $clog2(LL + 1);

    typedef struct {
        int acc;
        int due;
        int n;
        int extra;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  top = 4'b0111;
    logic [BW-1:0] busy_a, busy_b;

    int     cyc = 0;
    int     tests = 0;
    int     fails = 0;
    int     top_i = 7;
    int     tag = 0;
    int     last_n = 0;
    int     last_extra = 0;
    bit     mon_en = 1'b0;
    entry_t sb[$];

    pipelined_component_counter_multi_if #(.VAR_COUNT(VC), .COUNT_WIDTH(CWA), .EXTRA_DATA_WIDTH(EW)) bus_a ();
    pipelined_component_counter_multi_if #(.VAR_COUNT(VC), .COUNT_WIDTH(CWB), .EXTRA_DATA_WIDTH(EW)) bus_b ();

    pipelined_component_counter_multi #(
        .VAR_COUNT(VC), .LOOP_LATENCY(LL), .COUNT_WIDTH(CWA), .EXTRA_DATA_WIDTH(EW)
    ) dut_a (
        .clk(clk), .rst(rst), .top(top), .bus(bus_a.slave), .busy_count(busy_a)
    );

    pipelined_component_counter_multi #(
        .VAR_COUNT(VC), .LOOP_LATENCY(LL), .COUNT_WIDTH(CWB), .EXTRA_DATA_WIDTH(EW)
    ) dut_b (
        .clk(clk), .rst(rst), .top(top), .bus(bus_b.slave), .busy_count(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int n, input int cw);
        int mx;
        mx = (1 << cw) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic int ovf(input int n, input int cw);
        return (n > (1 << cw) - 1) ? 1 : 0;
    endfunction

    // Nodes a and b are adjacent when some top element covers both.
    function automatic bit adj(input int a, input int b, input int tp);
        for (int c = 0; c < W; c++)
            if (((tp >> c) & 1) == 1 && ((a | b) & ~c) == 0) return 1'b1;
        return 1'b0;
    endfunction

    // Components of the induced graph, and loop visits: one finish plus, per component,
    // a seed, one pass per BFS layer from its lowest node, and a terminating pass.
    function automatic void model(input int g, input int tp, output int vis, output int n);
        int rem, front, nxt, layers;
        rem = g;
        vis = 1;
        n = 0;
        for (int s = 0; s < W; s++) begin
            if (((rem >> s) & 1) == 1) begin
                n++;
                rem &= ~(1 << s);
                front = 1 << s;
                layers = 0;
                while (front != 0) begin
                    nxt = 0;
                    for (int a = 0; a < W; a++)
                        if (((front >> a) & 1) == 1)
                            for (int b = 0; b < W; b++)
                                if (((rem >> b) & 1) == 1 && adj(a, b, tp)) nxt |= (1 << b);
                    rem &= ~nxt;
                    if (nxt != 0) layers++;
                    front = nxt;
                end
                vis += 2 + layers;
            end
        end
    endfunction

    // Head at edge k is the slot of phase k mod LL; it is free unless an unfinished graph lives there.
    function automatic bit slot_free(input int k);
        foreach (sb[i])
            if ((sb[i].acc % LL) == (k % LL) && sb[i].due != k) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input bit v, input int g, input int ex, input bit r, input int vis, input int n);
        bit exp_rdy;
        @(negedge clk);
        rst = r;
        bus_a.in_valid = v;
        bus_a.graph_in = W'(g);
        bus_a.extra_in = EW'(ex);
        bus_b.in_valid = v;
        bus_b.graph_in = W'(g);
        bus_b.extra_in = EW'(ex);
        if (r) begin
            sb.delete();
            last_n = 0;
            last_extra = 0;
        end
        #1;
        exp_rdy = !r && slot_free(cyc + 1);
        chk("in_ready_a", int'(bus_a.in_ready), int'(exp_rdy));
        chk("in_ready_b", int'(bus_b.in_ready), int'(exp_rdy));
        if (v && exp_rdy)
            sb.push_back('{acc: cyc + 1, due: cyc + 1 + LL * vis, n: n, extra: ex & 1023});
    endtask

    task automatic send_rand(input bit v);
        int g, vis, n;
        g = $urandom_range(0, 15);
        model(g, top_i, vis, n);
        drive(v, g, tag, 1'b0, vis, n);
        tag = (tag + 1) & 1023;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 0, 0, 1'b0, 1, 0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            idle(1);
            guard++;
        end
        chk("drain_outstanding", sb.size(), 0);
    endtask

    initial begin : monitor
        int idx;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                idx = -1;
                foreach (sb[i]) if (sb[i].due == cyc) idx = i;
                if (idx >= 0) begin
                    chk("out_valid_a", int'(bus_a.out_valid), 1);
                    chk("out_valid_b", int'(bus_b.out_valid), 1);
                    chk("count_a", int'(bus_a.count_out), sat(sb[idx].n, CWA));
                    chk("count_b", int'(bus_b.count_out), sat(sb[idx].n, CWB));
                    chk("ovf_a", int'(bus_a.overflow_out), ovf(sb[idx].n, CWA));
                    chk("ovf_b", int'(bus_b.overflow_out), ovf(sb[idx].n, CWB));
                    chk("extra_a", int'(bus_a.extra_out), sb[idx].extra);
                    chk("extra_b", int'(bus_b.extra_out), sb[idx].extra);
                    last_n = sb[idx].n;
                    last_extra = sb[idx].extra;
                    sb.delete(idx);
                end else begin
                    chk("idle_valid_a", int'(bus_a.out_valid), 0);
                    chk("idle_valid_b", int'(bus_b.out_valid), 0);
                    chk("hold_count_a", int'(bus_a.count_out), sat(last_n, CWA));
                    chk("hold_ovf_b", int'(bus_b.overflow_out), ovf(last_n, CWB));
                    chk("hold_extra_a", int'(bus_a.extra_out), last_extra);
                end
                chk("busy_a", int'(busy_a), sb.size());
                chk("busy_b", int'(busy_b), sb.size());
            end
        end
    end

    initial begin
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        drive(1'b0, 0, 0, 1'b1, 1, 0);
        mon_en = 1'b1;
        drive(1'b0, 0, 0, 1'b1, 1, 0);

        // Directed cases with hand-derived visit counts (top = 0111).
        drive(1'b1, 4'b0000, 677, 1'b0, 1, 0);
        drain();
        drive(1'b1, 4'b0110, 300, 1'b0, 5, 2);
        drain();
        drive(1'b1, 4'b0111, 85, 1'b0, 4, 1);
        drain();

        // Back-to-back offers: ring fills, then refills on FINISH cycles.
        for (int k = 0; k < 60; k++) send_rand(1'b1);
        drain();

        // Reset with three graphs in flight, then accept on the first cycle out of reset.
        for (int k = 0; k < 3; k++) drive(1'b1, 4'b1110, 500 + k, 1'b0, 7, 3);
        idle(2);
        drive(1'b0, 0, 0, 1'b1, 1, 0);
        drive(1'b1, 4'b0000, 123, 1'b0, 1, 0);
        idle(40);
        drain();

        // Random traffic under several top masks, changed only while the ring is empty.
        for (int t = 0; t < 4; t++) begin
            if (t > 0) begin
                top_i = $urandom_range(0, 15);
                top = W'(top_i);
            end
            for (int k = 0; k < 150; k++) send_rand($urandom_range(0, 3) != 0);
            drain();
        end

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipelined_component_counter_multi.md
Name: pipelined_component_counter_multi

Overview:
- Generalised successor to the fixed-width connected-component counter core, for the monotone-function exploration datapath.
- Counts the connected components of a graph of 2^VAR_COUNT bits, bounded above by a per-core top mask.
- Keeps LOOP_LATENCY graphs in flight in a circular slot pipeline, with a valid/ready input and an output carrying count, overflow flag and sideband data.
- Replaces the fixed 128-bit/7-variable core; sits between the graph-feed FIFO and the result collector.

Parameters:
- VAR_COUNT, 7: number of variables; graph width W = 2^VAR_COUNT.
- LOOP_LATENCY, 8: cycles per loop iteration; also the number of slots. Minimum 2.
- COUNT_WIDTH, 6: width of the component counter.
- EXTRA_DATA_WIDTH, 10: sideband bits carried with each graph.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- top  in  W  upper-bound mask. Quasi-static: may change only while busy_count==0.
- in_valid  in  1  input graph offered.
- in_ready  out  1  the slot at the loop head accepts a graph this cycle.
- graph_in  in  W  graph to count.
- extra_in  in  EXTRA_DATA_WIDTH  sideband.
- out_valid  out  1  single-cycle result strobe. No backpressure.
- count_out  out  COUNT_WIDTH  component count.
- overflow_out  out  1  the count saturated.
- extra_out  out  EXTRA_DATA_WIDTH  sideband of the finished graph.
- busy_count  out  clog2(LOOP_LATENCY+1)  number of valid slots (profiling).

Behaviour:
- Slot state: valid, L (leftover, W bits), E (extending, W bits), cnt, ovf, extra.
- The loop head presents exactly one slot per cycle. A slot returns to the head every LOOP_LATENCY cycles.
- up(X): for each variable v and index i, set bit i|(1<<v) if bit i is set; transitive closure over all VAR_COUNT variables.
- down(X): the dual, setting bit i if bit i|(1<<v) is set; transitive closure.
- Head step, applied to a valid slot:
  - ACCEPT (slot free or FINISH, and in_valid): L=graph_in, E=0, cnt=0, ovf=0, extra=extra_in, valid=1.
  - FINISH (E==0 and L==0): emit the result and free the slot.
  - SEED (E==0 and L!=0): E = lowest set bit of L; L &= ~E; cnt += 1. If cnt is already all-ones it holds and ovf=1 (sticky).
  - EXPAND (E!=0): X = L & down(up(E) & top); E = X; L &= ~X. X==0 ends the component.
- in_ready = !head.valid || (head.E==0 && head.L==0). It is combinational from the head and independent of in_valid.
- FINISH and ACCEPT in the same cycle: the result is emitted and the same slot is reloaded. No bubble.
- Results:
  - out_valid/count_out/overflow_out/extra_out are registered, valid the cycle after FINISH.
  - Outputs hold their last value while out_valid=0.
  - Results leave in slot order, which may differ from input order.
- Latency:
  - An empty graph accepted at cycle t gives out_valid at t+LOOP_LATENCY+1.
  - In general: out_valid = t + LOOP_LATENCY*(1 + sum over components of (seed + expand passes + 1 terminating pass)) + 1.
- Freedom and fixed contract:
  - Internal retiming across the LOOP_LATENCY stages is free.
  - The iteration count per graph and the slot cadence are fixed.
- Reset:
  - All slots go invalid; outputs go to 0; in_ready=0 while rst=1.
  - Reset mid-operation discards in-flight graphs silently; no out_valid is produced for them.
  - The first accept is possible the cycle after rst deasserts.
- busy_count: registered count of valid slots.
- top is sampled every EXPAND step. Changing top while busy is undefined.

Test Plan:
- VAR_COUNT=2, LOOP_LATENCY=4, top=4'b0111. Accept graph 4'b0000 at t -> out_valid at t+5, count=0, ovf=0, extra echoed.
- Same config, graph 4'b0110 at t -> seed a, expand(0), seed b, expand(0), finish -> out_valid at t+21, count=2.
- Same config, graph 4'b0111 -> seed bit0, expand X=4'b0110, expand 0, finish -> count=1, out_valid at t+17.
- COUNT_WIDTH=1, graph 4'b0110, top=4'b0111 -> count=1, overflow_out=1.
- Back-to-back in_valid held with LOOP_LATENCY=4 -> 4 accepts on consecutive cycles, then in_ready=0 until a FINISH. On that FINISH cycle a new graph is accepted with no gap and busy_count stays 4.
- Assert rst for 1 cycle with 3 slots busy -> no out_valid afterwards, busy_count=0, in_ready=1 on the next cycle.
